video_stream_gen: RTL

Video stream generator. It produces the `vsync`/`hsync`/data pixel stream consumed by the filtering pipeline (the 1-D/2-D window sum and mean stages). It serves as the stimulus source on the simulation platform and as an on-chip test-pattern source. Output framing matches the pipeline input convention: `vsync` is high for the whole frame including vertical porches, `hsync` is high only on active pixels, and data is 0 whenever `hsync` is low.

---
 rtl/video_stream_gen_if.sv | 12 +
 rtl/video_stream_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/video_stream_gen_if.sv
// Pixel stream bundle carrying frame sync, active-pixel sync and pixel data
// from the generator to the filtering pipeline.
interface video_stream_gen_if #(
    parameter int DW = 8
);
    logic          dout_vsync;
    logic          dout_hsync;
    logic [DW-1:0] dout;

    modport master (output dout_vsync, dout_hsync, dout);
    modport slave  (input  dout_vsync, dout_hsync, dout);
endinterface

// File: rtl/video_stream_gen.sv
// Test-pattern video source: walks a frame raster and emits vsync/hsync/data
// with ramp, constant or LFSR content, optionally back-to-back with a fixed gap.
module video_stream_gen #(
    parameter int          DW    = 8,
    parameter int          H_BP  = 2,
    parameter int          H_ACT = 8,
    parameter int          H_FP  = 2,
    parameter int          V_BP  = 1,
    parameter int          V_ACT = 4,
    parameter int          V_FP  = 1,
    parameter int          F_GAP = 4,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic [1:0]            mode,
    input  logic [DW-1:0]         const_val,
    video_stream_gen_if.master    vid,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int H_TOT = H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_BP + V_ACT + V_FP;
    localparam int HW    = $clog2(H_TOT + 1);
    localparam int VW    = $clog2(V_TOT + 1);
    localparam int GW    = $clog2(F_GAP + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [GW-1:0] G_LAST = GW'(F_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [GW-1:0] r_gap_cnt;
    logic [1:0]    r_mode;
    logic [DW-1:0] r_const;
    logic [15:0]   r_lfsr;
    logic          r_vsync;
    logic          r_hsync;
    logic [DW-1:0] r_dout;
    logic          r_busy;
    logic          r_done;

    logic          w_enter;
    logic          w_last;
    logic          w_step;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    int            w_x;
    int            w_y;
    logic          w_active;
    logic [1:0]    w_mode_eff;
    logic [DW-1:0] w_const_eff;
    logic [15:0]   w_lfsr_base;
    logic [15:0]   w_lfsr_adv;
    logic [DW-1:0] w_pixel;

    // Output registers hold the raster position being presented; the logic
    // below computes the position and pixel for the following cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_h_nxt     = '0;
        w_v_nxt     = '0;
        w_pixel     = '0;
        w_enter     = ((r_state == S_IDLE) && start) ||
                      ((r_state == S_GAP) && (r_gap_cnt == G_LAST));
        w_last      = (r_state == S_FRAME) && (r_h == H_LAST) && (r_v == V_LAST);
        w_step      = w_enter || ((r_state == S_FRAME) && !w_last);
        w_mode_eff  = w_enter ? mode : r_mode;
        w_const_eff = w_enter ? const_val : r_const;
        w_lfsr_base = w_enter ? SEED : r_lfsr;
        w_lfsr_adv  = {w_lfsr_base[14:0],
                       w_lfsr_base[15] ^ w_lfsr_base[13] ^ w_lfsr_base[12] ^ w_lfsr_base[10]};

        if (!w_enter) begin
            if (r_h == H_LAST) begin
                w_v_nxt = (r_v == V_LAST) ? '0 : r_v + VW'(1);
            end else begin
                w_h_nxt = r_h + HW'(1);
                w_v_nxt = r_v;
            end
        end

        w_x      = int'(w_h_nxt) - H_BP;
        w_y      = int'(w_v_nxt) - V_BP;
        w_active = (w_x >= 0) && (w_x < H_ACT) && (w_y >= 0) && (w_y < V_ACT);

        if (w_active) begin
            unique case (w_mode_eff)
                2'd0:    w_pixel = DW'(w_x + w_y);
                2'd1:    w_pixel = w_const_eff;
                2'd2:    w_pixel = w_lfsr_base[DW-1:0];
                default: w_pixel = DW'(w_x);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
        if (rst) begin
            r_state   <= S_IDLE;
            r_h       <= '0;
            r_v       <= '0;
            r_gap_cnt <= '0;
            r_mode    <= 2'd0;
            r_const   <= '0;
            r_lfsr    <= SEED;
            r_vsync   <= 1'b0;
            r_hsync   <= 1'b0;
            r_dout    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FRAME;
                    end
                end
                S_FRAME: begin
                    if (w_last) begin
                        r_vsync   <= 1'b0;
                        r_hsync   <= 1'b0;
                        r_dout    <= '0;
                        r_done    <= 1'b1;
                        r_gap_cnt <= '0;
                        if (cont) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (w_enter) begin
                        r_state <= S_FRAME;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_enter) begin
                r_mode  <= mode;
                r_const <= const_val;
            end

            // The LFSR restarts from SEED each frame and moves only on active pixels.
            if (w_step) begin
                r_h     <= w_h_nxt;
                r_v     <= w_v_nxt;
                r_vsync <= 1'b1;
                r_busy  <= 1'b1;
                r_hsync <= w_active;
                r_dout  <= w_pixel;
                if (w_active) begin
                    r_lfsr <= w_lfsr_adv;
                end else if (w_enter) begin
                    r_lfsr <= SEED;
                end
            end
        end
    end

    assign vid.dout_vsync = r_vsync;
    assign vid.dout_hsync = r_hsync;
    assign vid.dout       = r_dout;
    assign busy           = r_busy;
    assign frame_done     = r_done;

endmodule
